// File: rtl/vec_mac_accel.sv
// Grouped dot-product accelerator on the xbar slave bus: A[N], B[N] -> NRES results of G=N/NRES MACs.
// Define VEC_MAC_IRQ_EN to add irq_o, CTRL.irq_en and the STATUS.done write-1-to-clear.
module vec_mac_accel #(
  parameter int DW   = 16,
  parameter int N    = 8,
  parameter int NRES = 4
) (
  input  logic        clk_i,
  input  logic        srst_n_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_i,
  input  logic [3:0]  bus_be_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_o
`ifdef VEC_MAC_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int G    = N / NRES;
  localparam int GW   = $clog2(G);
  localparam int IW   = $clog2(N);
  localparam int ACCW = 2*DW + GW;
  localparam int PW   = 2*DW + 2;
  localparam int EW   = (ACCW > PW) ? ACCW : PW;
  localparam int AW   = $clog2(8*N + 4*NRES + 8);
  localparam int WAW  = AW - 2;

  localparam logic [WAW-1:0] B_BASE = WAW'(N);
  localparam logic [WAW-1:0] R_BASE = WAW'(2*N);
  localparam logic [WAW-1:0] CTRL_W = WAW'(2*N + NRES);
  localparam logic [WAW-1:0] STAT_W = WAW'(2*N + NRES + 1);
  localparam logic [IW-1:0]  GMASK  = IW'(G - 1);
  localparam logic [IW-1:0]  LAST   = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     a_q [N];
  logic [DW-1:0]     a_d [N];
  logic [DW-1:0]     b_q [N];
  logic [DW-1:0]     b_d [N];
  logic [31:0]       r_q [NRES];
  logic [31:0]       r_d [NRES];
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              sgn_q, sgn_d;
  logic              done_q, done_d;
  logic              ack_q, ack_d;
  logic              resp_q, resp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_en_rd;
`ifdef VEC_MAC_IRQ_EN
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
`endif

  logic              accept, wr_ok, rd_ok, busy;
  logic [WAW-1:0]    word;
  logic signed [DW:0]   op_a, op_b;
  logic signed [PW-1:0] prod;
  logic signed [EW-1:0] prod_w;
  logic [ACCW-1:0]   acc_sum;
  logic [31:0]       res;
  logic              unused_bits;

  assign unused_bits = ^{bus_addr_i[31:AW], bus_addr_i[1:0], bus_wdata_i};

`ifdef VEC_MAC_IRQ_EN
  assign irq_en_rd = irq_en_q;
`else
  assign irq_en_rd = 1'b0;
`endif

  // NOTE: every *_d takes its *_q value first, so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sgn_d   = sgn_q;
    done_d  = done_q;
`ifdef VEC_MAC_IRQ_EN
    irq_en_d = irq_en_q;
    irq_d    = irq_q;
`endif

    accept  = bus_req_i && !ack_q;
    wr_ok   = accept && bus_we_i && (bus_be_i == 4'hF);
    rd_ok   = accept && !bus_we_i;
    busy    = (state_q != S_IDLE);
    word    = bus_addr_i[AW-1:2];
    ack_d   = accept;
    resp_d  = rd_ok;
    rdata_d = '0;

    // Signed mode sign-extends each operand by one bit; unsigned mode zero-extends.
    op_a    = $signed({sgn_q & a_q[idx_q][DW-1], a_q[idx_q]});
    op_b    = $signed({sgn_q & b_q[idx_q][DW-1], b_q[idx_q]});
    prod    = op_a * op_b;
    prod_w  = EW'(prod);
    acc_sum = acc_q + prod_w[ACCW-1:0];
    res     = sgn_q ? 32'($signed(acc_sum)) : 32'(acc_sum);

    if (rd_ok) begin
      if (word < B_BASE)       rdata_d = 32'(a_q[word[IW-1:0]]);
      else if (word < R_BASE)  rdata_d = 32'(b_q[word[IW-1:0]]);
      else if (word == CTRL_W) rdata_d = {29'b0, irq_en_rd, sgn_q, 1'b0};
      else if (word == STAT_W) rdata_d = {30'b0, busy, done_q | (state_q == S_DONE)};
      else begin
        for (int k = 0; k < NRES; k++)
          if (word == R_BASE + WAW'(k)) rdata_d = r_q[k];
      end
    end

    if (wr_ok && !busy) begin
      if (word < B_BASE)      a_d[word[IW-1:0]] = bus_wdata_i[DW-1:0];
      else if (word < R_BASE) b_d[word[IW-1:0]] = bus_wdata_i[DW-1:0];
      else if (word == CTRL_W) begin
        sgn_d = bus_wdata_i[1];
`ifdef VEC_MAC_IRQ_EN
        irq_en_d = bus_wdata_i[2];
`endif
        if (bus_wdata_i[0]) begin
          state_d = S_RUN;
          idx_d   = '0;
          acc_d   = '0;
          done_d  = 1'b0;
          for (int k = 0; k < NRES; k++) r_d[k] = '0;
`ifdef VEC_MAC_IRQ_EN
          irq_d   = 1'b0;
`endif
        end
      end
    end

`ifdef VEC_MAC_IRQ_EN
    if (wr_ok && (word == STAT_W) && bus_wdata_i[0]) begin
      done_d = 1'b0;
      irq_d  = 1'b0;
    end
`endif

    case (state_q)
      S_RUN: begin
        if ((idx_q & GMASK) == GMASK) begin
          acc_d = '0;
          for (int k = 0; k < NRES; k++)
            if (int'(idx_q >> GW) == k) r_d[k] = res;
        end else begin
          acc_d = acc_sum;
        end
        if (idx_q == LAST) state_d = S_DONE;
        else               idx_d   = idx_q + IW'(1);
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef VEC_MAC_IRQ_EN
        irq_d   = irq_q | irq_en_q;
`endif
      end
      default: ;
    endcase
  end

  // NOTE: operand and result arrays are reset too, so a reset mid-run leaves no stale data behind.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q  <= S_IDLE;
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      r_q      <= '{default: '0};
      acc_q    <= '0;
      idx_q    <= '0;
      sgn_q    <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
`ifdef VEC_MAC_IRQ_EN
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      sgn_q    <= sgn_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
`ifdef VEC_MAC_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

  assign bus_ack_o   = ack_q;
  assign bus_resp_o  = resp_q;
  assign bus_rdata_o = rdata_q;
`ifdef VEC_MAC_IRQ_EN
  assign irq_o       = irq_q;
`endif

endmodule
